// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: DEPTH-entry elastic pipeline register between two stages.
// Carries control and data separately so bubbles and killed entries always
// present the NOP control word, with hold (stall), flush and per-entry kill.
module pipe_stage_buffer #(
   parameter int unsigned       DATA_W   = 96,
   parameter int unsigned       CTRL_W   = 8,
   parameter int unsigned       DEPTH    = 2,
   parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
   parameter logic [DATA_W-1:0] NOP_DATA = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_kill,
   input  logic [CTRL_W-1:0]          in_ctrl,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CTRL_W-1:0]          out_ctrl,
   output logic [DATA_W-1:0]          out_data,
   input  logic                       hold,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
   localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   logic [CTRL_W-1:0] ctrl_q [DEPTH];
   logic [CTRL_W-1:0] ctrl_d [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              push;
   logic              pop;

   // Handshake: acceptance never looks at out_ready, so a full buffer stays closed.
   always_comb begin
      in_ready  = reset && (count_q < FULL_CNT) && !hold && !flush;
      out_valid = (count_q != '0);
      push      = in_valid && in_ready;
      pop       = out_valid && out_ready && !hold && !flush;
   end

   // Next-state: flush wins over everything; push/pop move modulo-DEPTH pointers.
   always_comb begin
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) begin
            ctrl_d[wptr_q] = in_kill ? NOP_CTRL : in_ctrl;
            data_d[wptr_q] = in_kill ? NOP_DATA : in_data;
            wptr_d         = (wptr_q == LAST_PTR) ? '0 : wptr_q + PTR_W'(1);
         end
         if (pop) begin
            rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Head read straight from storage; an empty buffer shows the bubble.
   always_comb begin
      out_ctrl = NOP_CTRL;
      out_data = NOP_DATA;
      if (out_valid) begin
         out_ctrl = ctrl_q[rptr_q];
         out_data = data_q[rptr_q];
      end
      count = count_q;
   end

   // State registers; reset empties the buffer and refills storage with NOPs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            ctrl_q[i] <= NOP_CTRL;
            data_q[i] <= NOP_DATA;
         end
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer (DEPTH=2): directed stimulus, queue scoreboard
// checked by a monitor on the falling edge, plus directed spot checks.
module tb_pipe_stage_buffer;

   localparam int unsigned DATA_W = 96;
   localparam int unsigned CTRL_W = 8;
   localparam int unsigned DEPTH  = 2;

   typedef logic [CTRL_W+DATA_W-1:0] entry_t;

   logic              clk;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic              in_kill;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic              hold;
   logic              flush;
   logic [1:0]        count;

   int     n_chk  = 0;
   int     n_pass = 0;
   int     n_pops = 0;
   int     p0;
   entry_t sb [$];

   pipe_stage_buffer #(
      .DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH),
      .NOP_CTRL('0), .NOP_DATA('0)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_kill(in_kill),
      .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_ctrl(out_ctrl), .out_data(out_data),
      .hold(hold), .flush(flush), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Monitor: compare DUT against the scoreboard mid-cycle, then advance the model.
   always @(negedge clk) begin : mon
      int unsigned sz;
      bit          exp_ready;
      bit          m_push;
      bit          m_pop;
      entry_t      head;
      if (!reset) begin
         sb.delete();
         chk(count == 2'd0, "rst_count", 128'(count), 128'(0));
         chk(!out_valid, "rst_out_valid", 128'(out_valid), 128'(0));
         chk(!in_ready, "rst_in_ready", 128'(in_ready), 128'(0));
         chk({out_ctrl, out_data} == '0, "rst_bubble", 128'({out_ctrl, out_data}), 128'(0));
      end else begin
         sz        = sb.size();
         exp_ready = (sz < DEPTH) && !hold && !flush;
         head      = (sz != 0) ? sb[0] : '0;
         chk(in_ready == exp_ready, "in_ready", 128'(in_ready), 128'(exp_ready));
         chk(out_valid == (sz != 0), "out_valid", 128'(out_valid), 128'(sz != 0));
         chk(count == 2'(sz), "count", 128'(count), 128'(sz));
         chk({out_ctrl, out_data} == head, (sz != 0) ? "head" : "bubble",
             128'({out_ctrl, out_data}), 128'(head));
         m_pop  = (sz != 0) && out_ready && !hold && !flush;
         m_push = in_valid && exp_ready;
         if (flush) sb.delete();
         else begin
            if (m_pop) begin
               void'(sb.pop_front());
               n_pops++;
            end
            if (m_push) sb.push_back(in_kill ? entry_t'(0) : {in_ctrl, in_data});
         end
      end
   end

   // Protocol assertions: no push into a full buffer, no pop from empty, no overflow.
   always @(negedge clk) begin
      if (reset) begin
         n_chk++;
         a_no_push_full: assert (!(in_valid && in_ready && count == 2'(DEPTH))) n_pass++;
            else $display("FAIL push_while_full: count %0d", count);
         n_chk++;
         a_no_pop_empty: assert (!(out_valid && out_ready && !hold && !flush && count == 2'd0)) n_pass++;
            else $display("FAIL pop_while_empty: count %0d", count);
         n_chk++;
         a_cnt_range: assert (count <= 2'(DEPTH)) n_pass++;
            else $display("FAIL count_range: got %0d max %0d", count, DEPTH);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input bit k, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
      in_valid = v;
      in_kill  = k;
      in_ctrl  = c;
      in_data  = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0; out_ready = 1'b0; hold = 1'b0; flush = 1'b0;
      drive(0, 0, '0, '0);
      step(); step();
      chk(!in_ready, "ready_in_reset", 128'(in_ready), 128'(0));
      reset = 1'b1;
      step();

      // First push: bubble before, entry visible one edge later
      chk({out_valid, out_ctrl, out_data} == '0, "pre_push", 128'({out_valid, out_ctrl, out_data}), 128'(0));
      drive(1, 0, 8'h5A, 96'h1);
      step();
      drive(0, 0, '0, '0);
      chk(out_valid, "t1_valid", 128'(out_valid), 128'(1));
      chk(out_ctrl == 8'h5A, "t1_ctrl", 128'(out_ctrl), 128'(8'h5A));
      chk(out_data == 96'h1, "t1_data", 128'(out_data), 128'(1));
      chk(count == 2'd1, "t1_count", 128'(count), 128'(1));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk(count == 2'd0, "t1_drain", 128'(count), 128'(0));

      // Full buffer backpressure, ordered drain, C only after space frees
      drive(1, 0, 8'h11, 96'hA); step();
      drive(1, 0, 8'h22, 96'hB); step();
      drive(1, 0, 8'h33, 96'hC); step();
      chk(count == 2'd2, "t2_full", 128'(count), 128'(2));
      chk(!in_ready, "t2_ready_full", 128'(in_ready), 128'(0));
      step();
      chk(out_ctrl == 8'h11, "t2_head_a", 128'(out_ctrl), 128'(8'h11));
      out_ready = 1'b1;
      chk(!in_ready, "t2_no_accept_on_pop", 128'(in_ready), 128'(0));
      step();
      chk(out_ctrl == 8'h22, "t2_head_b", 128'(out_ctrl), 128'(8'h22));
      chk(in_ready, "t2_ready_after_pop", 128'(in_ready), 128'(1));
      step();
      drive(0, 0, '0, '0);
      chk(out_ctrl == 8'h33 && out_data == 96'hC, "t2_head_c", 128'({out_ctrl, out_data}), 128'({8'h33, 96'hC}));
      chk(count == 2'd1, "t2_count_c", 128'(count), 128'(1));
      step();
      out_ready = 1'b0;
      chk(count == 2'd0, "t2_empty", 128'(count), 128'(0));

      // Kill: slot used, NOP shown
      drive(1, 1, 8'hFF, '1);
      step();
      drive(0, 0, '0, '0);
      chk(count == 2'd1, "t3_count", 128'(count), 128'(1));
      chk(out_valid, "t3_valid", 128'(out_valid), 128'(1));
      chk(out_ctrl == 8'h00, "t3_ctrl_nop", 128'(out_ctrl), 128'(0));
      chk(out_data == 96'h0, "t3_data_nop", 128'(out_data), 128'(0));

      // Hold freezes a full buffer despite in_valid and out_ready
      drive(1, 0, 8'h44, 96'h44);
      step();
      chk(count == 2'd2, "t4_full", 128'(count), 128'(2));
      hold = 1'b1; out_ready = 1'b1;
      drive(1, 0, 8'h55, 96'h55);
      for (int i = 0; i < 3; i++) begin
         step();
         chk(count == 2'd2, "t4_hold_count", 128'(count), 128'(2));
         chk(!in_ready, "t4_hold_ready", 128'(in_ready), 128'(0));
         chk(out_valid && out_ctrl == 8'h00 && out_data == 96'h0, "t4_hold_head",
             128'({out_valid, out_ctrl}), 128'({1'b1, 8'h00}));
      end
      hold = 1'b0;
      drive(0, 0, '0, '0);
      step();
      chk(count == 2'd1 && out_ctrl == 8'h44, "t4_resume", 128'({count, out_ctrl}), 128'({2'd1, 8'h44}));
      step();
      out_ready = 1'b0;
      chk(count == 2'd0, "t4_empty", 128'(count), 128'(0));

      // Flush beats hold and push; offered entry is lost
      drive(1, 0, 8'h66, 96'h66); step();
      drive(1, 0, 8'h77, 96'h77); step();
      chk(count == 2'd2, "t5_full", 128'(count), 128'(2));
      flush = 1'b1; hold = 1'b1;
      drive(1, 0, 8'h88, 96'h88);
      step();
      flush = 1'b0; hold = 1'b0;
      drive(0, 0, '0, '0);
      chk(count == 2'd0, "t5_count", 128'(count), 128'(0));
      chk(!out_valid, "t5_valid", 128'(out_valid), 128'(0));
      chk({out_ctrl, out_data} == '0, "t5_bubble", 128'({out_ctrl, out_data}), 128'(0));
      step();
      chk(count == 2'd0 && !out_valid, "t5_dropped", 128'({count, out_valid}), 128'(0));

      // Streaming: one entry per clock through wrapping pointers
      out_ready = 1'b1;
      p0 = n_pops;
      for (int i = 0; i < 10; i++) begin
         drive(1, 0, 8'(i + 1), 96'(i) * 96'h1000_0001);
         step();
         chk(count == 2'd1, "t6_stream_count", 128'(count), 128'(1));
         chk(in_ready, "t6_stream_ready", 128'(in_ready), 128'(1));
      end
      drive(0, 0, '0, '0);
      step();
      chk(n_pops - p0 == 10, "t6_rate", 128'(n_pops - p0), 128'(10));
      chk(count == 2'd0, "t6_empty", 128'(count), 128'(0));

      // Asynchronous reset in the middle of a stream
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 8'(8'hA0 + i), 96'(i + 100));
         step();
      end
      #1 reset = 1'b0;
      #1;
      chk(count == 2'd0, "t7_async_count", 128'(count), 128'(0));
      chk(!out_valid, "t7_async_valid", 128'(out_valid), 128'(0));
      chk(!in_ready, "t7_async_ready", 128'(in_ready), 128'(0));
      drive(0, 0, '0, '0);
      out_ready = 1'b0;
      step(); step();
      reset = 1'b1;
      step();
      chk(count == 2'd0 && !out_valid, "t7_after_reset", 128'({count, out_valid}), 128'(0));
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
